// File: rtl/neunet_acc_rf.sv
// Accumulator register file behind the four-lane FP MAC pipe: masked writebacks, a write-through
// read port for the datac addend, and clear/drain sequencers that stream rows to the host side.
module neunet_acc_rf #(
  parameter int unsigned ROWS  = 32,
  parameter int unsigned LANES = 4,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     wb_reg_wen,
  input  logic [LANES-1:0]         wb_word_sel,
  input  logic [$clog2(ROWS)-1:0]  wb_index,
  input  logic [LANES*DW-1:0]      wb_result,
  input  logic [LANES-1:0]         wb_nan,
  input  logic [$clog2(ROWS)-1:0]  rd_index,
  output logic [LANES*DW-1:0]      rd_data,
  input  logic                     clear_req,
  input  logic                     drain_req,
  input  logic [$clog2(ROWS)-1:0]  drain_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(ROWS)-1:0]  out_index,
  output logic [LANES*DW-1:0]      out_data,
  output logic                     drain_done,
  output logic                     busy,
  output logic                     nan_err,
  output logic [$clog2(ROWS)-1:0]  nan_index,
  input  logic                     nan_clr
);

  localparam int unsigned IW = $clog2(ROWS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [DW-1:0] mem [ROWS][LANES];

  logic [1:0]          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       last_q, last_d;
  logic                out_valid_q, out_valid_d;
  logic [IW-1:0]       out_index_q, out_index_d;
  logic [LANES*DW-1:0] out_data_q, out_data_d;
  logic                drain_done_q, drain_done_d;
  logic                busy_q;
  logic                nan_err_q, nan_err_d;
  logic [IW-1:0]       nan_index_q, nan_index_d;

  logic                clearing;
  logic                nan_hit;
  logic                capture;
  logic                clear_entry;
  logic [IW-1:0]       cap_idx;
  logic [LANES*DW-1:0] cap_row;

  assign clearing = (state_q == ST_CLEAR);
  assign nan_hit  = wb_reg_wen & (|(wb_nan & wb_word_sel));

  // Row picked up by a drain capture: row 0 on entry, the following row on each handshake.
  always_comb begin
    cap_idx = '0;
    if (state_q == ST_DRAIN) begin
      cap_idx = ptr_q + 1'b1;
    end
  end

  // Both the read port and the drain capture see the write-first value of their row.
  always_comb begin
    rd_data = '0;
    cap_row = '0;
    for (int k = 0; k < LANES; k++) begin
      rd_data[DW*k +: DW] = mem[rd_index][k];
      if (clearing && (ptr_q == rd_index)) begin
        rd_data[DW*k +: DW] = '0;
      end
      if (wb_reg_wen && (wb_index == rd_index) && wb_word_sel[k]) begin
        rd_data[DW*k +: DW] = wb_result[DW*k +: DW];
      end

      cap_row[DW*k +: DW] = mem[cap_idx][k];
      if (clearing && (ptr_q == cap_idx)) begin
        cap_row[DW*k +: DW] = '0;
      end
      if (wb_reg_wen && (wb_index == cap_idx) && wb_word_sel[k]) begin
        cap_row[DW*k +: DW] = wb_result[DW*k +: DW];
      end
    end
  end

  // Storage is not reset; a clear pass is what initialises it.
  always_ff @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < LANES; k++) begin
        if (wb_reg_wen && (wb_index == IW'(r)) && wb_word_sel[k]) begin
          mem[r][k] <= wb_result[DW*k +: DW];
        end else if (clearing && (ptr_q == IW'(r))) begin
          mem[r][k] <= '0;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    last_d       = last_q;
    out_valid_d  = out_valid_q;
    out_index_d  = out_index_q;
    out_data_d   = out_data_q;
    drain_done_d = 1'b0;
    capture      = 1'b0;
    clear_entry  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d     = ST_CLEAR;
          ptr_d       = '0;
          clear_entry = 1'b1;
        end else if (drain_req) begin
          state_d     = ST_DRAIN;
          ptr_d       = '0;
          last_d      = drain_last;
          capture     = 1'b1;
          out_index_d = '0;
          out_valid_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == IW'(ROWS - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (ptr_q == last_q) begin
            out_valid_d  = 1'b0;
            drain_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            ptr_d       = ptr_q + 1'b1;
            out_index_d = ptr_q + 1'b1;
            capture     = 1'b1;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    if (capture) begin
      out_data_d = cap_row;
    end
  end

  // A new NaN beats a same-cycle nan_clr; only the first NaN since clearing records its row.
  always_comb begin
    nan_err_d   = nan_err_q;
    nan_index_d = nan_index_q;
    if (clear_entry) begin
      nan_err_d   = 1'b0;
      nan_index_d = '0;
    end else if (nan_hit) begin
      nan_err_d = 1'b1;
      if (!nan_err_q) begin
        nan_index_d = wb_index;
      end
    end else if (nan_clr) begin
      nan_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      last_q       <= '0;
      out_valid_q  <= 1'b0;
      out_index_q  <= '0;
      out_data_q   <= '0;
      drain_done_q <= 1'b0;
      busy_q       <= 1'b0;
      nan_err_q    <= 1'b0;
      nan_index_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      last_q       <= last_d;
      out_valid_q  <= out_valid_d;
      out_index_q  <= out_index_d;
      out_data_q   <= out_data_d;
      drain_done_q <= drain_done_d;
      busy_q       <= (state_d != ST_IDLE);
      nan_err_q    <= nan_err_d;
      nan_index_q  <= nan_index_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_index  = out_index_q;
  assign out_data   = out_data_q;
  assign drain_done = drain_done_q;
  assign busy       = busy_q;
  assign nan_err    = nan_err_q;
  assign nan_index  = nan_index_q;

endmodule

// File: tb/tb_neunet_acc_rf.sv
// Self-checking bench for neunet_acc_rf: directed steps with random data, checked against a
// plain array model of the accumulator rows.
module tb_neunet_acc_rf;

  logic         clk = 1'b0;
  logic         nreset;
  logic         wb_reg_wen;
  logic [3:0]   wb_word_sel;
  logic [4:0]   wb_index;
  logic [127:0] wb_result;
  logic [3:0]   wb_nan;
  logic [4:0]   rd_index;
  logic [127:0] rd_data;
  logic         clear_req;
  logic         drain_req;
  logic [4:0]   drain_last;
  logic         out_valid;
  logic         out_ready;
  logic [4:0]   out_index;
  logic [127:0] out_data;
  logic         drain_done;
  logic         busy;
  logic         nan_err;
  logic [4:0]   nan_index;
  logic         nan_clr;

  int n_cmp = 0;
  int n_err = 0;

  bit [31:0] mm [32][4];

  always #5 clk = ~clk;

  neunet_acc_rf dut (
    .clk         (clk),
    .nreset      (nreset),
    .wb_reg_wen  (wb_reg_wen),
    .wb_word_sel (wb_word_sel),
    .wb_index    (wb_index),
    .wb_result   (wb_result),
    .wb_nan      (wb_nan),
    .rd_index    (rd_index),
    .rd_data     (rd_data),
    .clear_req   (clear_req),
    .drain_req   (drain_req),
    .drain_last  (drain_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .out_data    (out_data),
    .drain_done  (drain_done),
    .busy        (busy),
    .nan_err     (nan_err),
    .nan_index   (nan_index),
    .nan_clr     (nan_clr)
  );

  function automatic logic [127:0] mrow(input int r);
    logic [127:0] v;
    for (int k = 0; k < 4; k++) v[32*k +: 32] = mm[r][k];
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_write(input int idx, input logic [3:0] sel, input logic [127:0] d);
    for (int k = 0; k < 4; k++) if (sel[k]) mm[idx][k] = d[32*k +: 32];
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) for (int k = 0; k < 4; k++) mm[r][k] = '0;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_set(input int idx, input logic [3:0] sel, input logic [127:0] d,
                        input logic [3:0] nan);
    wb_reg_wen  = 1'b1;
    wb_index    = idx[4:0];
    wb_word_sel = sel;
    wb_result   = d;
    wb_nan      = nan;
  endtask

  task automatic wb_off();
    wb_reg_wen = 1'b0;
    wb_nan     = '0;
  endtask

  // Counts cycles with busy high after a request was accepted, bounded.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    int cnt;
    int b;
    int c;
    int idx;
    int rd;
    bit wrote;
    logic [3:0]   sel;
    logic [127:0] d;
    logic [127:0] exp;
    logic [127:0] beat_exp [4];

    nreset = 1'b0; wb_reg_wen = 1'b0; wb_word_sel = '0; wb_index = '0; wb_result = '0;
    wb_nan = '0; rd_index = '0; clear_req = 1'b0; drain_req = 1'b0; drain_last = '0;
    out_ready = 1'b0; nan_clr = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_drain_done", drain_done, 0);
    chk("rst_nan_err", nan_err, 0);
    chk("rst_nan_index", nan_index, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_data", out_data, 0);
    nreset = 1'b1;
    tick();

    // Clear: busy for exactly ROWS cycles, then every row reads zero
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    count_busy(cnt);
    chk("clear_busy_cycles", cnt, 32);
    model_clear();
    for (int r = 0; r < 32; r++) begin
      rd_index = r[4:0];
      #1;
      chk($sformatf("clear_row%0d", r), rd_data, mrow(r));
    end

    // Masked writeback with same-cycle bypass
    wb_set(5, 4'b0101, {4{32'h3F80_0000}}, 4'b0000);
    rd_index = 5'd5;
    #1;
    chk("wb5_bypass", rd_data, 128'h00000000_3F800000_00000000_3F800000);
    tick();
    wb_off();
    model_write(5, 4'b0101, {4{32'h3F80_0000}});
    #1;
    chk("wb5_stored", rd_data, 128'h00000000_3F800000_00000000_3F800000);

    // Random writebacks with bypass reads
    for (int i = 0; i < 30; i++) begin
      idx = $urandom_range(0, 31);
      sel = 4'($urandom_range(0, 15));
      d   = rnd128();
      rd  = ($urandom_range(0, 1) == 1) ? idx : $urandom_range(0, 31);
      wb_set(idx, sel, d, 4'b0000);
      rd_index = rd[4:0];
      #1;
      exp = mrow(rd);
      if (rd == idx) for (int k = 0; k < 4; k++) if (sel[k]) exp[32*k +: 32] = d[32*k +: 32];
      chk($sformatf("rand_rd%0d", i), rd_data, exp);
      tick();
      model_write(idx, sel, d);
    end
    wb_off();

    // Drain rows 0..3 under continuous ready
    for (int r = 0; r < 4; r++) begin
      d = rnd128();
      wb_set(r, 4'hF, d, 4'b0000);
      tick();
      model_write(r, 4'hF, d);
    end
    wb_off();
    drain_req = 1'b1; drain_last = 5'd3; out_ready = 1'b1;
    tick();
    drain_req = 1'b0;
    for (int bb = 0; bb < 4; bb++) begin
      chk($sformatf("dr3_valid%0d", bb), out_valid, 1);
      chk($sformatf("dr3_index%0d", bb), out_index, bb);
      chk($sformatf("dr3_data%0d", bb), out_data, mrow(bb));
      tick();
    end
    chk("dr3_done", drain_done, 1);
    chk("dr3_valid_low", out_valid, 0);
    chk("dr3_busy_low", busy, 0);
    tick();
    chk("dr3_done_pulse", drain_done, 0);

    // Drain with stalls and a writeback to the stalled row
    for (int r = 0; r < 4; r++) beat_exp[r] = mrow(r);
    drain_req = 1'b1; drain_last = 5'd3; out_ready = 1'b0;
    tick();
    drain_req = 1'b0;
    b = 0; c = 0; wrote = 1'b0;
    while (b < 4 && c < 40) begin
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      chk($sformatf("st_valid_c%0d", c), out_valid, 1);
      chk($sformatf("st_index_c%0d", c), out_index, b);
      chk($sformatf("st_data_c%0d", c), out_data, beat_exp[b]);
      d = rnd128();
      if (b == 1 && !out_ready && !wrote) wb_set(1, 4'hF, d, 4'b0000);
      tick();
      if (wb_reg_wen) begin
        model_write(1, 4'hF, d);
        wrote = 1'b1;
        wb_off();
      end
      if (out_ready) b++;
      c++;
    end
    out_ready = 1'b0;
    chk("st_beats", b, 4);
    chk("st_done", drain_done, 1);
    chk("st_valid_low", out_valid, 0);
    rd_index = 5'd1;
    #1;
    chk("st_row1_new", rd_data, mrow(1));

    // NaN tracking
    d = rnd128();
    wb_set(9, 4'b0010, d, 4'b0010);
    tick();
    model_write(9, 4'b0010, d);
    wb_off();
    chk("nan9_err", nan_err, 1);
    chk("nan9_index", nan_index, 9);
    d = rnd128();
    wb_set(12, 4'b0100, d, 4'b0100);
    tick();
    model_write(12, 4'b0100, d);
    wb_off();
    chk("nan12_err", nan_err, 1);
    chk("nan12_keep9", nan_index, 9);
    nan_clr = 1'b1;
    tick();
    nan_clr = 1'b0;
    chk("nan_clr", nan_err, 0);
    d = rnd128();
    wb_set(7, 4'b0001, d, 4'b0010);
    tick();
    model_write(7, 4'b0001, d);
    wb_off();
    chk("nan_unsel", nan_err, 0);
    d = rnd128();
    wb_set(20, 4'b1000, d, 4'b1000);
    nan_clr = 1'b1;
    tick();
    model_write(20, 4'b1000, d);
    wb_off();
    nan_clr = 1'b0;
    chk("nan_set_wins", nan_err, 1);
    chk("nan20_index", nan_index, 20);

    // Reset mid-drain, restart, then clear beats a simultaneous drain request
    drain_req = 1'b1; drain_last = 5'd5; out_ready = 1'b1;
    tick();
    drain_req = 1'b0;
    tick(); tick();
    chk("mid_index2", out_index, 2);
    nreset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", drain_done, 0);
    tick();
    nreset = 1'b1;
    tick();
    drain_req = 1'b1; drain_last = 5'd0; out_ready = 1'b0;
    tick();
    drain_req = 1'b0;
    chk("re_busy", busy, 1);
    chk("re_index", out_index, 0);
    chk("re_data", out_data, mrow(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("re_done", drain_done, 1);
    chk("re_valid_low", out_valid, 0);
    tick();
    clear_req = 1'b1; drain_req = 1'b1; drain_last = 5'd31;
    tick();
    clear_req = 1'b0; drain_req = 1'b0;
    chk("both_no_valid", out_valid, 0);
    count_busy(cnt);
    chk("both_clear_cycles", cnt, 32);
    model_clear();
    rd_index = 5'd3;
    #1;
    chk("both_row3_zero", rd_data, mrow(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/neunet_acc_rf.md
Name: neunet_acc_rf

Overview:
- Accumulator register file directly downstream of the four-lane floating-point MAC pipe.
- Captures MAC writebacks (result, lane mask, row index, NaN flags) into a ROWS x LANES x DW array.
- Provides a zero-latency read port with write-through bypass, so the issue stage can source the datac addend for accumulation.
- Contains a clear sequencer and a valid/ready drain sequencer that stream finished rows out to the host/DMA side.

Parameters:
ROWS, 32, number of accumulator rows; index width is log2(ROWS) = 5
LANES, 4, lanes per row; equals MAC lane count and lane-mask width
DW, 32, IEEE-754 single word width

Ports:
clk  in  1  clock; all state updates on rising edge
nreset  in  1  asynchronous, active-low reset
wb_reg_wen  in  1  MAC writeback strobe
wb_word_sel  in  LANES  lane write mask; bit k enables lane k
wb_index  in  5  writeback row
wb_result  in  LANES*DW  lane k on bits [DW*k+DW-1 : DW*k]
wb_nan  in  LANES  per-lane NaN flag from the MAC adders
rd_index  in  5  read-port row
rd_data  out  LANES*DW  combinational row read, feeds datac
clear_req  in  1  pulse: zero all rows
drain_req  in  1  pulse: stream rows 0..drain_last
drain_last  in  5  last row to drain; sampled with drain_req
out_valid  out  1  drain stream valid
out_ready  in  1  drain stream ready
out_index  out  5  row number of out_data
out_data  out  LANES*DW  drained row
drain_done  out  1  one-cycle pulse after the final handshake
busy  out  1  FSM not in IDLE
nan_err  out  1  sticky NaN error
nan_index  out  5  row of the first NaN writeback since the last clear
nan_clr  in  1  clears nan_err

Behaviour:
- Reset (async, nreset=0):
  - State goes to IDLE and the pointer to 0.
  - out_valid, drain_done, busy, nan_err, nan_index, out_index and out_data all go to 0.
  - Array contents are NOT reset and are undefined until a clear completes.
- Writeback: when wb_reg_wen=1, lanes with wb_word_sel[k]=1 of row wb_index take wb_result lane k at the clock edge. Unselected lanes hold. Writebacks are accepted in every state.
- Read port: rd_data = array[rd_index], with a same-cycle bypass. If wb_reg_wen=1 and wb_index==rd_index, selected lanes return wb_result. The bypass is the value as it will be after this edge, including a clear-row overlap.
- FSM states: IDLE, CLEAR, DRAIN.
- IDLE:
  - clear_req goes to CLEAR with ptr=0.
  - Otherwise drain_req goes to DRAIN with ptr=0 and last=drain_last latched.
  - clear_req has priority if both are asserted.
- CLEAR:
  - Each cycle, all lanes of row ptr are written 0, then ptr increments.
  - After ptr=ROWS-1 is written, go to IDLE. Duration is exactly ROWS cycles.
  - A writeback to row ptr in the same cycle wins per selected lane; unselected lanes are zeroed.
  - Clear also resets nan_err and nan_index to 0 on entry.
- DRAIN:
  - On entry, row 0 is captured into out_data; out_valid=1 from the next cycle.
  - Captures use the write-first value, i.e. include a same-cycle writeback to that row.
  - out_data and out_index are stable while out_valid=1 and out_ready=0. Writebacks to the captured row during a stall do not alter out_data.
  - On handshake (out_valid & out_ready) with ptr<last: capture row ptr+1 in the same edge. out_valid stays 1, giving one row per cycle under continuous ready.
  - On handshake with ptr==last: out_valid=0 next cycle, drain_done=1 for one cycle, return to IDLE.
  - drain_last=0 drains exactly one row.
- Requests while busy=1 are ignored; they are not queued.
- busy = (state != IDLE), registered with state.
- NaN tracking:
  - If wb_reg_wen and any (wb_nan[k] & wb_word_sel[k]), nan_err is set next cycle.
  - nan_index is captured only if nan_err was 0; the first NaN is retained.
  - If set and nan_clr occur in the same cycle, set wins.
- Reset mid-operation aborts CLEAR/DRAIN immediately with no drain_done. A partially cleared array is left as is.

Test Plan:
1. Reset, clear_req pulse -> busy=1 for exactly 32 cycles. Then rd_index sweeps 0..31 and every rd_data returns 0.
2. Writeback: wb_index=5, wb_word_sel=4'b0101, lanes 0x3F800000 -> rd_index=5 returns 0x3F800000 in lanes 0 and 2, 0 in lanes 1 and 3. The same value appears combinationally in the write cycle (bypass).
3. Fill rows 0..3 with distinct values, drain_req with drain_last=3, out_ready=1 -> four consecutive beats, out_index 0,1,2,3, correct data. drain_done pulses one cycle after beat 3; busy falls with it.
4. Same drain with out_ready toggled 1,0,0,1,...; writeback to row 1 while it is stalled on output -> out_data and out_index hold during stalls. Row 1 beat shows the pre-write value; a later read shows the new value.
5. Writeback wb_index=9, wb_nan=4'b0010, wb_word_sel=4'b0010 -> nan_err=1, nan_index=9. A second NaN at row 12 keeps nan_index=9. A NaN with its lane unselected does not set nan_err. nan_clr together with a new NaN -> nan_err stays 1.
6. Assert nreset low mid-drain at beat 2 -> out_valid, busy and drain_done are 0 immediately. After release, drain_req restarts from row 0; clear_req and drain_req in the same cycle -> CLEAR is taken.
